// File: rtl/memory_ram_if.sv
// rtl/memory_ram_if.sv - request/response bus between a client and memory_ram
interface memory_ram_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic [WIDTH-1:0]  req_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/memory_ram.sv
// rtl/memory_ram.sv - single-port RAM with bit masks, zero sweep and a one-entry response register
module memory_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  memory_ram_if.slave     bus,
  output logic            init_busy
);
  localparam int ADDR_W1 = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [ADDR_W:0]   DEPTH_W   = ADDR_W1'(DEPTH);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              init_busy_q, init_busy_d;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              addr_ok;
  logic              accept;
  logic [WIDTH-1:0]  mem_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  assign addr_ok       = ({1'b0, bus.req_addr} < DEPTH_W);
  // A held, unconsumed response stalls every request so it cannot be overwritten.
  assign bus.req_ready = (state_q == ST_READY) && (!rsp_valid_q || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign mem_rdata     = addr_ok ? mem[bus.req_addr] : '0;

  // Next-state: sweep sequencing, request decode and response register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    init_busy_d = init_busy_q;
    mem_we      = 1'b0;
    mem_waddr   = bus.req_addr;
    mem_wdata   = '0;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_READY;
          init_busy_d = 1'b0;
          cnt_d       = '0;
        end
      end
      ST_READY: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
        if (accept) begin
          if (bus.req_we) begin
            // Out-of-range writes are dropped without any indication.
            mem_we    = addr_ok;
            mem_wdata = (mem_rdata & ~bus.req_wmask) | (bus.req_wdata & bus.req_wmask);
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mem_rdata;
            rsp_err_d   = !addr_ok;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control and response registers; reset restarts the sweep and drops any response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      init_busy_q <= init_busy_d;
    end
  end

  // Storage array; deliberately not reset, the sweep defines its contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign init_busy     = init_busy_q;
endmodule

// File: doc/memory_ram.md
# memory_ram

Parametrised synchronous single-port RAM, the clocked successor to the latch-based 1-bit memory. It stores DEPTH words of WIDTH bits and supports per-bit write masks. Requests use a valid/ready interface; read data returns through a one-entry, backpressurable response register. After every reset the array is swept to zero before the block accepts traffic. It sits between the datapath and any client that needs scratch storage.

## Interface
Parameters:
- WIDTH, default 8: word width in bits (≥1).
- DEPTH, default 16: number of words (≥2, need not be a power of 2).
- ADDR_W, default $clog2(DEPTH): address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  WIDTH  write data.
- req_wmask  in  WIDTH  per-bit write enable (1 = bit updated).
- rsp_valid  out  1  read response held.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  WIDTH  read data.
- rsp_err  out  1  the read address was ≥ DEPTH.
- init_busy  out  1  zero-sweep in progress.

## Operation
- FSM states are INIT and READY. rst_n low forces INIT, clears the sweep counter to 0, and sets rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=1 and req_ready=0.
- INIT:
  - Each clock writes 0 to mem[cnt] and increments cnt.
  - The write at cnt==DEPTH-1 moves the FSM to READY.
  - init_busy=1 throughout. Requests are ignored (req_ready=0).
- READY:
  - init_busy=0.
  - req_ready = !rsp_valid | rsp_ready. This is combinational from rsp_valid and rsp_ready; it never depends on req_valid.
  - A request is accepted on a clock edge where req_valid & req_ready.
- Accepted write:
  - mem[addr] <= (mem[addr] & ~req_wmask) | (req_wdata & req_wmask).
  - No response is generated.
  - If addr ≥ DEPTH, the write is discarded silently.
- Accepted read:
  - On the same edge, rsp_valid <= 1 and rsp_rdata <= mem[addr] (the contents before the edge).
  - rsp_err <= (addr ≥ DEPTH). When rsp_err=1, rsp_rdata=0.
- Response register:
  - rsp_valid & rsp_ready with no new read accepted → rsp_valid <= 0. rsp_rdata and rsp_err hold their last values.
  - rsp_valid & rsp_ready with a new read accepted on the same edge → the register reloads and rsp_valid stays 1 (back-to-back reads at full throughput).
  - rsp_valid & !rsp_ready → req_ready=0. The register holds, and no request of either type is accepted.
- Memory contents are not reset directly by rst_n. They are defined only after the sweep.
- Reset asserted mid-sweep or mid-transaction: any pending response is dropped and the sweep restarts at address 0.

## Timing
- Init latency: init_busy is high for exactly DEPTH rising edges after rst_n deasserts. req_ready can first be 1 in the cycle after the DEPTH-th edge.
- Read latency: 1 cycle. A read accepted at edge N is visible on rsp_rdata and rsp_valid after edge N.
- Write-to-read: a write accepted at edge N, followed by a read of the same address accepted at edge N+1, returns the new data.
- Throughput: 1 request per cycle while rsp_ready=1 or no response is pending.
- Outputs are registered, except req_ready, which is combinational as defined above.

## Test plan
- Reset/init, DEPTH=16: release rst_n → init_busy=1 for 16 edges, then 0. Reading all addresses returns 0 with rsp_err=0.
- Masked write, WIDTH=8: write 0xFF to addr 3 with mask 0xFF, then write 0x00 with mask 0x0F. A read of addr 3 returns 0xF0 one cycle after acceptance.
- Back-to-back reads with rsp_ready held at 1: write 0x11, 0x22, 0x33 to addrs 0, 1, 2, then issue three consecutive reads. rsp_valid stays high for 3 cycles with data 0x11, 0x22, 0x33 and no bubbles.
- Backpressure: read addr 1, hold rsp_ready=0 for 4 cycles while req_valid=1 with a write to addr 1 → req_ready=0 and rsp_rdata stable throughout. After rsp_ready=1, the write is accepted, and a subsequent read returns the new value.
- Out-of-range, DEPTH=12: write 0xAA to addr 13, then read addr 13 → rsp_err=1, rsp_rdata=0. All of addrs 0-11 still read 0.
- Reset mid-sweep and mid-response:
  - Assert rst_n low at sweep edge 5 → init_busy restarts and lasts the full 16 edges.
  - Assert rst_n low while rsp_valid=1 → rsp_valid=0 immediately (asynchronous), and memory reads 0 after the sweep.
